// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared definitions for the RTC bus master.
//   - state_t          : bus sequencer states
//   - AD_ADDR / AD_DATA: levels of the ad phase indicator
//   - T_*_DEF          : default phase lengths in clock cycles
//   - max4 / cnt_width : helpers that size the phase counter from the T_* values
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_A_SU,
    S_A_WR,
    S_A_H,
    S_D_SU,
    S_D_STB,
    S_D_H,
    S_REC
  } state_t;

  localparam logic AD_ADDR = 1'b0;
  localparam logic AD_DATA = 1'b1;

  localparam int T_SU_DEF  = 2;
  localparam int T_PW_DEF  = 4;
  localparam int T_H_DEF   = 2;
  localparam int T_REC_DEF = 3;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // The counter holds (phase length - 1), so a longest phase of 1 still needs one bit.
  function automatic int cnt_width(input int max_t);
    return (max_t > 1) ? $clog2(max_t) : 1;
  endfunction

endpackage

// File: rtl/rtc_bus_master_timer.sv
// rtc_phase_timer: phase down-counter for the RTC bus master.
//   clk      : system clock
//   rst      : synchronous reset, active-low
//   load     : load load_val this cycle (state entry)
//   load_val : phase length - 1
//   zero     : counter is 0, i.e. the current cycle is the last of the phase
module rtc_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/rtc_bus_master.sv
// rtc_bus_master: Intel-style multiplexed address/data RTC bus sequencer with
// programmable phase timing and burst transfers (address auto-increment).
//   clk, rst                    : clock, synchronous active-low reset
//   req/ready/busy              : request handshake (accepted in IDLE only)
//   rw, start_addr, len         : request descriptor, sampled with req
//   wdata, wdata_ack            : write word source and its one-cycle pop
//   rdata, rdata_valid          : last read word and its one-cycle strobe
//   done                        : one-cycle pulse at the end of a request
//   cs_n, wr_n, rd_n, ad        : bus strobes and address/data phase flag
//   ad_out, ad_oe, ad_in        : pad drive value, drive enable, sampled value
// All outputs are registered; they are decoded from the next state so they line
// up with the state they describe.
module rtc_bus_master
  import rtc_bus_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int LEN_W     = $clog2(MAX_BURST + 1),
  parameter int T_SU      = T_SU_DEF,
  parameter int T_PW      = T_PW_DEF,
  parameter int T_H       = T_H_DEF,
  parameter int T_REC     = T_REC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              ready,
  input  logic              rw,
  input  logic [DATA_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              done,
  output logic              busy,
  output logic              cs_n,
  output logic              wr_n,
  output logic              rd_n,
  output logic              ad,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  input  logic [DATA_W-1:0] ad_in
);

  localparam int CNT_W = cnt_width(max4(T_SU, T_PW, T_H, T_REC));

  localparam logic [CNT_W-1:0] LD_SU  = CNT_W'(T_SU - 1);
  localparam logic [CNT_W-1:0] LD_PW  = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] LD_H   = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0] LD_REC = CNT_W'(T_REC - 1);

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  addr, addr_nxt;
  logic [DATA_W-1:0]  data_reg, data_nxt;
  logic [LEN_W-1:0]   remaining;
  logic               rw_q;
  logic               t_zero, t_load;
  logic [CNT_W-1:0]   t_val;
  logic               accept, word_end, wr_pop;

  assign accept   = (state == S_IDLE) && req;
  assign word_end = (state == S_REC) && t_zero;
  assign wr_pop   = (state == S_A_H) && t_zero && !rw_q;

  // NOTE: every combinational output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req && len != '0) state_nxt = S_A_SU;
      S_A_SU:  if (t_zero) state_nxt = S_A_WR;
      S_A_WR:  if (t_zero) state_nxt = S_A_H;
      S_A_H:   if (t_zero) state_nxt = S_D_SU;
      S_D_SU:  if (t_zero) state_nxt = S_D_STB;
      S_D_STB: if (t_zero) state_nxt = S_D_H;
      S_D_H:   if (t_zero) state_nxt = S_REC;
      S_REC:   if (t_zero) state_nxt = (remaining == LEN_W'(1)) ? S_IDLE : S_A_SU;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    addr_nxt = addr;
    if (accept)
      addr_nxt = start_addr;
    else if (word_end)
      addr_nxt = addr + DATA_W'(1);
  end

  always_comb begin
    data_nxt = data_reg;
    if (wr_pop) data_nxt = wdata;
  end

  // Every transition enters a different state, so a state change is exactly a phase entry.
  assign t_load = (state_nxt != state);

  always_comb begin
    t_val = '0;
    case (state_nxt)
      S_A_SU, S_D_SU:  t_val = LD_SU;
      S_A_WR, S_D_STB: t_val = LD_PW;
      S_A_H, S_D_H:    t_val = LD_H;
      S_REC:           t_val = LD_REC;
      default:         t_val = '0;
    endcase
  end

  rtc_phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      ready       <= 1'b1;
      cs_n        <= 1'b1;
      wr_n        <= 1'b1;
      rd_n        <= 1'b1;
      ad          <= AD_DATA;
      ad_oe       <= 1'b0;
      ad_out      <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      wdata_ack   <= 1'b0;
      done        <= 1'b0;
      addr        <= '0;
      data_reg    <= '0;
      remaining   <= '0;
      rw_q        <= 1'b0;
    end else begin
      state       <= state_nxt;
      ready       <= (state_nxt == S_IDLE);
      addr        <= addr_nxt;
      data_reg    <= data_nxt;
      wdata_ack   <= wr_pop;
      rdata_valid <= 1'b0;
      done        <= 1'b0;

      if (accept) begin
        rw_q      <= rw;
        remaining <= len;
        if (len == '0) done <= 1'b1;
      end

      // ad_in is taken on the last strobe cycle; rdata appears the cycle after.
      if (state == S_D_STB && t_zero && rw_q) begin
        rdata       <= ad_in;
        rdata_valid <= 1'b1;
      end

      if (word_end) begin
        remaining <= remaining - LEN_W'(1);
        if (remaining == LEN_W'(1)) done <= 1'b1;
      end

      case (state_nxt)
        S_A_SU, S_A_WR, S_A_H: begin
          cs_n   <= 1'b0;
          wr_n   <= (state_nxt != S_A_WR);
          rd_n   <= 1'b1;
          ad     <= AD_ADDR;
          ad_oe  <= 1'b1;
          ad_out <= addr_nxt;
        end
        S_D_SU, S_D_STB, S_D_H: begin
          cs_n  <= 1'b0;
          wr_n  <= !(state_nxt == S_D_STB && !rw_q);
          rd_n  <= !(state_nxt == S_D_STB && rw_q);
          ad    <= AD_DATA;
          ad_oe <= !rw_q;
          if (!rw_q) ad_out <= data_nxt;
        end
        default: begin
          cs_n  <= 1'b1;
          wr_n  <= 1'b1;
          rd_n  <= 1'b1;
          ad    <= AD_DATA;
          ad_oe <= 1'b0;
        end
      endcase
    end
  end

  assign busy = ~ready;

endmodule

// File: tb/tb_rtc_bus_master.sv
// tb_rtc_bus_master: scoreboard bench for rtc_bus_master (default timing) plus a
// second instance built with T_PW=1.
module tb_rtc_bus_master;
  import rtc_bus_pkg::*;

  localparam int T_PW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b1;
  logic       req1 = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] start_addr = 8'h00;
  logic [4:0] len = 5'd1;
  logic [7:0] wdata = 8'h00;
  logic [7:0] ad_in;

  logic       ready, busy, wdata_ack, rdata_valid, done;
  logic       cs_n, wr_n, rd_n, ad, ad_oe;
  logic [7:0] rdata, ad_out;

  logic       ready1, busy1, wdata_ack1, rdata_valid1, done1;
  logic       cs_n1, wr_n1, rd_n1, ad1, ad_oe1;
  logic [7:0] rdata1, ad_out1;

  always #5 clk = ~clk;

  rtc_bus_master dut (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .rw(rw),
    .start_addr(start_addr), .len(len), .wdata(wdata), .wdata_ack(wdata_ack),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .busy(busy),
    .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .ad(ad), .ad_out(ad_out),
    .ad_oe(ad_oe), .ad_in(ad_in)
  );

  rtc_bus_master #(.T_PW(1)) dut_pw1 (
    .clk(clk), .rst(rst), .req(req1), .ready(ready1), .rw(rw),
    .start_addr(start_addr), .len(len), .wdata(wdata), .wdata_ack(wdata_ack1),
    .rdata(rdata1), .rdata_valid(rdata_valid1), .done(done1), .busy(busy1),
    .cs_n(cs_n1), .wr_n(wr_n1), .rd_n(rd_n1), .ad(ad1), .ad_out(ad_out1),
    .ad_oe(ad_oe1), .ad_in(ad_in)
  );

  // RTC device model: latches the address on the address strobe, returns mem[addr].
  logic [7:0] mem [256];
  logic [7:0] dev_addr = 8'h00;
  always @(negedge clk)
    if (cs_n === 1'b0 && ad === AD_ADDR && wr_n === 1'b0) dev_addr = ad_out;
  assign ad_in = mem[dev_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int done_cnt = 0;

  logic [7:0] exp_addr [$];
  logic [7:0] exp_wdata [$];
  logic [7:0] exp_ack [$];
  logic [7:0] exp_rdata [$];
  int         exp_done [$];

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  int         wr_lo = 0, rd_lo = 0;
  logic       wr_q = 1'b1, rd_q = 1'b1;
  logic       ad_at_fall = 1'b1;
  logic [7:0] m_e;
  int         m_d;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      wr_lo = 0; rd_lo = 0; wr_q = 1'b1; rd_q = 1'b1;
    end else begin
      if (wr_n === 1'b0) begin
        if (wr_q) begin
          ad_at_fall = ad;
          if (ad === AD_ADDR) begin
            if (exp_addr.size() == 0) check(0, "addr_unexpected", ad_out, 0);
            else begin m_e = exp_addr.pop_front(); check(ad_out === m_e, "addr", ad_out, m_e); end
          end else begin
            check(ad_oe === 1'b1, "wr_data_oe", ad_oe, 1);
            if (exp_wdata.size() == 0) check(0, "wdata_unexpected", ad_out, 0);
            else begin m_e = exp_wdata.pop_front(); check(ad_out === m_e, "wr_data", ad_out, m_e); end
          end
        end else
          check(ad === ad_at_fall, "ad_stable_wr", ad, ad_at_fall);
        wr_lo++;
      end else if (!wr_q) begin
        check(wr_lo == T_PW, "wr_width", wr_lo, T_PW);
        wr_lo = 0;
      end

      if (rd_n === 1'b0) begin
        if (rd_q) begin
          ad_at_fall = ad;
          check(ad === AD_DATA, "rd_phase", ad, AD_DATA);
        end else
          check(ad === ad_at_fall, "ad_stable_rd", ad, ad_at_fall);
        check(ad_oe === 1'b0, "rd_oe", ad_oe, 0);
        rd_lo++;
      end else if (!rd_q) begin
        check(rd_lo == T_PW, "rd_width", rd_lo, T_PW);
        rd_lo = 0;
      end

      if (wr_n === 1'b0 || rd_n === 1'b0)
        check(!(wr_n === 1'b0 && rd_n === 1'b0), "strobe_overlap", {wr_n, rd_n}, 2'b11);

      wr_q = (wr_n !== 1'b0);
      rd_q = (rd_n !== 1'b0);
    end

    if (wdata_ack === 1'b1) begin
      if (exp_ack.size() == 0) check(0, "ack_unexpected", ad_out, 0);
      else begin m_e = exp_ack.pop_front(); check(ad_out === m_e, "ack_data", ad_out, m_e); end
    end
    if (rdata_valid === 1'b1) begin
      if (exp_rdata.size() == 0) check(0, "rdata_unexpected", rdata, 0);
      else begin m_e = exp_rdata.pop_front(); check(rdata === m_e, "rdata", rdata, m_e); end
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_done.size() == 0) check(0, "done_unexpected", cyc, 0);
      else begin
        m_d = exp_done.pop_front();
        check(cyc == m_d, "done_cycle", cyc, m_d);
        check(ready === 1'b1, "ready_at_done", ready, 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_req(input logic r, input logic [7:0] a, input logic [4:0] n,
                           input bit expect_done);
    int t = 0;
    while (ready !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
    if (ready !== 1'b1) check(0, "ready_timeout", ready, 1);
    rw = r; start_addr = a; len = n; req = 1'b1;
    if (expect_done) begin
      exp_done.push_back(cyc + 1 + 19 * int'(n));
      acc_cnt++;
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_done.size() != 0 || ready !== 1'b1) && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 2000) check(0, "drain_timeout", exp_done.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    int t, k1, lows, falls, done_at;
    bit prev;

    foreach (mem[i]) mem[i] = 8'h00;
    mem[0] = 8'h30; mem[1] = 8'h45; mem[2] = 8'h12; mem[3] = 8'h99;

    // Reset held 3 cycles with req high.
    repeat (3) @(posedge clk);
    #1; rst = 1'b1; req = 1'b0;
    @(negedge clk);
    check(ready === 1'b1 && busy === 1'b0, "rst_ready", {ready, busy}, 2'b10);
    check({cs_n, wr_n, rd_n, ad} === 4'b1111, "rst_strobes", {cs_n, wr_n, rd_n, ad}, 4'hf);
    check(ad_oe === 1'b0, "rst_oe", ad_oe, 0);
    check(rdata === 8'h00 && ad_out === 8'h00, "rst_data", {rdata, ad_out}, 0);
    check(done === 1'b0, "rst_done", done, 0);
    @(posedge clk); #1;

    // Single write 59 -> 04.
    exp_addr.push_back(8'h04);
    exp_wdata.push_back(8'h59); exp_ack.push_back(8'h59);
    wdata = 8'h59;
    pulse_req(1'b0, 8'h04, 5'd1, 1'b1);
    drain();

    // Burst read of 3 from 00.
    exp_addr.push_back(8'h00); exp_addr.push_back(8'h01); exp_addr.push_back(8'h02);
    exp_rdata.push_back(8'h30); exp_rdata.push_back(8'h45); exp_rdata.push_back(8'h12);
    pulse_req(1'b1, 8'h00, 5'd3, 1'b1);
    drain();

    // Address wrap: write burst of 2 from FF.
    exp_addr.push_back(8'hFF); exp_addr.push_back(8'h00);
    exp_wdata.push_back(8'hA1); exp_wdata.push_back(8'hB2);
    exp_ack.push_back(8'hA1); exp_ack.push_back(8'hB2);
    wdata = 8'hA1;
    pulse_req(1'b0, 8'hFF, 5'd2, 1'b1);
    t = 0;
    do begin @(negedge clk); t++; end while (wdata_ack !== 1'b1 && t < 100);
    if (wdata_ack !== 1'b1) check(0, "ack_timeout", wdata_ack, 1);
    @(posedge clk); #1; wdata = 8'hB2;
    drain();

    // len=0: done next cycle, bus idle.
    pulse_req(1'b0, 8'h33, 5'd0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      check(cs_n === 1'b1 && ad_oe === 1'b0, "len0_bus_idle", {cs_n, ad_oe}, 2'b10);
    end
    drain();

    // req while busy is ignored.
    exp_addr.push_back(8'h10);
    exp_wdata.push_back(8'h77); exp_ack.push_back(8'h77);
    wdata = 8'h77;
    pulse_req(1'b0, 8'h10, 5'd1, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    req = 1'b1; rw = 1'b1; start_addr = 8'h80; len = 5'd2;
    @(posedge clk); #1; req = 1'b0;
    drain();

    // Reset during word 2 strobe of a 4-word read.
    exp_addr.push_back(8'h00); exp_addr.push_back(8'h01);
    exp_rdata.push_back(8'h30);
    pulse_req(1'b1, 8'h00, 5'd4, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    check(rd_n === 1'b0, "midrst_in_strobe", rd_n, 0);
    rst = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check({cs_n, wr_n, rd_n} === 3'b111, "midrst_strobes", {cs_n, wr_n, rd_n}, 3'b111);
    check(ad_oe === 1'b0 && ready === 1'b1, "midrst_idle", {ad_oe, ready}, 2'b01);
    check(rdata === 8'h00, "midrst_rdata", rdata, 0);
    repeat (60) @(posedge clk);
    #1;

    // T_PW=1 instance: single write 5A -> 20, period 13.
    wdata = 8'h5A; rw = 1'b0; start_addr = 8'h20; len = 5'd1;
    t = 0;
    while (ready1 !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
    req1 = 1'b1; k1 = cyc;
    @(posedge clk); #1; req1 = 1'b0;
    lows = 0; falls = 0; prev = 1'b1; done_at = -1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (wr_n1 === 1'b0) begin
        lows++;
        if (prev) begin
          falls++;
          if (falls == 1) check(ad_out1 === 8'h20, "pw1_addr", ad_out1, 8'h20);
          else            check(ad_out1 === 8'h5A, "pw1_data", ad_out1, 8'h5A);
        end
      end
      prev = (wr_n1 !== 1'b0);
      if (done1 === 1'b1) done_at = cyc;
    end
    check(lows == 2 && falls == 2, "pw1_strobe_width", {lows[15:0], falls[15:0]}, 32'h00020002);
    check(done_at == k1 + 1 + 13, "pw1_done_cycle", done_at, k1 + 14);

    // Final bookkeeping.
    check(done_cnt == acc_cnt, "done_count", done_cnt, acc_cnt);
    check(exp_addr.size() + exp_wdata.size() + exp_ack.size() + exp_rdata.size()
          + exp_done.size() == 0, "queues_empty",
          exp_addr.size() + exp_wdata.size() + exp_rdata.size() + exp_done.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
